fp_add_sched: RTL and testbench
===============================

# fp_add_sched

Round-robin scheduler that shares one `fp_add` datapath among `NREQ` requesters. It sits between client blocks and a single adder instance. It arbitrates pending requests and latches the winner's operands. It drives the adder's `restart`/`start` protocol, including the stale-`done` hazard, and returns the result to the winning requester with a one-cycle valid pulse.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: RUN cycles allowed before an abort, 4..255. Used only with `FP_SCHED_TIMEOUT_EN`.

- `clk`  in  1  clock. All logic is posedge.
- `restart`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  level request per client. Held until `gnt` and may be withdrawn before it.
- `op_a`  in  32*NREQ  packed operand A. Client i occupies bits [32i+31:32i].
- `op_b`  in  32*NREQ  packed operand B, same packing as `op_a`.
- `gnt`  out  NREQ  one-hot, 1-cycle pulse. Operands are sampled on this edge.
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse to the granted client.
- `rsp_sum`  out  32  result. Valid with `rsp_valid` and held until the next response.
- `rsp_err`  out  1  timeout flag. Qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `add_n1`, `add_n2`  out  32 each  adder operands. Stable from LOAD through RESP.
- `add_start`  out  1  adder start. High only in RUN.
- `add_restart`  out  1  adder synchronous restart. High in IDLE, LOAD and RESP.
- `add_sum`  in  32  adder result.
- `add_done`  in  1  adder done. Sticky until the adder processes a new start.

## Operation
- States: IDLE, LOAD, RUN, RESP. All outputs are registered.
- Async reset:
  - state=IDLE, round-robin pointer `ptr`=0, `run_cnt`=0.
  - `gnt`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_err`=0, `busy`=0.
  - `add_n1`=`add_n2`=0, `add_start`=0, `add_restart`=1.
- IDLE:
  - If `req`≠0, pick the winner w = first set bit searching from `ptr` upward, with wrap.
  - Next state LOAD.
  - Registered on that edge: `gnt[w]`=1, `add_n1`=`op_a[w]`, `add_n2`=`op_b[w]`, latched index=w, `ptr`=(w+1) mod NREQ.
- LOAD:
  - `gnt` returns to 0 and `add_restart` stays 1. Lasts one cycle.
  - Next state RUN, with `run_cnt`=0.
- RUN:
  - `add_start`=1, `add_restart`=0. `run_cnt` increments each cycle, saturating at 255.
  - `add_done` is ignored while `run_cnt`<2. The adder's `done` is not cleared by `restart`, only by its first start cycle.
  - When `add_done`=1 and `run_cnt`≥2: next state RESP and `rsp_sum`=`add_sum`.
- RESP:
  - `rsp_valid[w]`=1 for one cycle.
  - `add_start`=0, `add_restart`=1.
  - Next state IDLE. No new grant is issued in RESP.
- Requests arriving during LOAD, RUN or RESP wait. Their `op_a`/`op_b` are not sampled until their own `gnt`.
- A withdrawn `req` (dropped before `gnt`) is simply not granted. `ptr` does not move.
- Simultaneous requests are served in round-robin order. No client waits more than NREQ-1 transactions.
- Reset mid-transaction aborts immediately: no `rsp_valid`, `ptr`=0, adder held in restart.

## Timing
- `req` sampled in IDLE → `gnt` high in the next cycle (LOAD).
- `add_start` rises 2 cycles after the request edge.
- `rsp_valid` occurs 1 cycle after the qualifying `add_done` sample.
- Minimum request-to-response time is 5 cycles plus the adder latency (about 9–33 cycles).
- Back-to-back throughput: one transaction per (adder latency + 4) cycles. IDLE→LOAD→RUN→RESP→IDLE is the minimum loop.
- `rsp_sum` is written only on RESP entry.

## Configuration
- `FP_SCHED_TIMEOUT_EN` defined:
  - In RUN, if `run_cnt` reaches `TIMEOUT` without a qualifying `add_done`, go to RESP.
  - On that RESP: `rsp_err`=1, `rsp_sum`=0, `rsp_valid[w]` pulses.
  - `rsp_err` is cleared on the next normal RESP.
- `FP_SCHED_TIMEOUT_EN` undefined:
  - No abort path; RUN waits indefinitely.
  - `rsp_err` is tied to 0 and `TIMEOUT` is unused.

## Test plan
- Single client 0: `op_a`=0x3F800000, `op_b`=0x40000000 → `gnt`=0001 one cycle after `req`, then `rsp_valid`=0001 with `rsp_sum`=0x40400000 and `rsp_err`=0.
- `req`=1010 asserted together with different operands per client → grants 0010 then 1000, each with a correct sum. Then `req`=1111 → order 0001, 0010, 0100, 1000.
- Back-to-back from client 2 with 0x40400000+0x3F800000 after a prior transaction (`add_done` still 1 at RUN entry) → first RUN cycle's `done` ignored, `rsp_sum`=0x40800000, not the previous result.
- Assert `restart` in cycle 5 of RUN → no `rsp_valid`, all outputs at reset values, `add_restart`=1. A following `req`=0100 is served normally and `ptr` restarts from 0.
- With `FP_SCHED_TIMEOUT_EN` defined, `TIMEOUT`=8 and an adder stub that never raises `done` → `rsp_valid` pulses 8 RUN cycles after start with `rsp_err`=1 and `rsp_sum`=0. The next real transaction returns `rsp_err`=0.
- Client 3 raises `req` then drops it during another client's RUN → client 3 never receives `gnt` and `ptr` is unaffected.

Source files
------------

// File: rtl/fp_add_sched.sv
// Round-robin scheduler that shares one fp_add datapath among NREQ requesters.
// Optional RUN-cycle timeout abort is compiled in when FP_SCHED_TIMEOUT_EN is defined.
module fp_add_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                i_clk,
    input  logic                i_restart,
    input  logic [NREQ-1:0]     i_req,
    input  logic [32*NREQ-1:0]  i_op_a,
    input  logic [32*NREQ-1:0]  i_op_b,
    output logic [NREQ-1:0]     o_gnt,
    output logic [NREQ-1:0]     o_rsp_valid,
    output logic [31:0]         o_rsp_sum,
    output logic                o_rsp_err,
    output logic                o_busy,
    output logic [31:0]         o_add_n1,
    output logic [31:0]         o_add_n2,
    output logic                o_add_start,
    output logic                o_add_restart,
    input  logic [31:0]         i_add_sum,
    input  logic                i_add_done
);

    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]     NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("fp_add_sched: NREQ must be within 2..8");
    end
    if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fp_add_sched: TIMEOUT must be within 4..255");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t          r_state, w_state_n;
    logic [PW-1:0]   r_ptr, w_ptr_n;
    logic [PW-1:0]   r_idx, w_idx_n;
    logic [7:0]      r_run_cnt, w_cnt_n;
    logic [NREQ-1:0] r_gnt, w_gnt_n;
    logic [NREQ-1:0] r_rsp_valid, w_valid_n;
    logic [31:0]     r_rsp_sum, w_sum_n;
    logic            r_rsp_err, w_err_n;
    logic            r_busy, r_start, r_restart;
    logic [31:0]     r_n1, w_n1_n, r_n2, w_n2_n;

    logic [2*NREQ-1:0] w_req2;
    logic [NREQ-1:0]   w_rot;
    logic [PW-1:0]     w_off, w_win;
    logic [PW:0]       w_pos;
    logic              w_found;
    logic [31:0]       w_win_a, w_win_b;

    // Rotate requests so the pointer lands at bit 0; lowest set bit is the winner.
    always_comb begin
        w_req2  = {i_req, i_req} >> r_ptr;
        w_rot   = w_req2[NREQ-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = PW'(k);
            end
        end
        w_pos = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_pos >= NREQ_W) begin
            w_pos = w_pos - NREQ_W;
        end
        w_win   = w_pos[PW-1:0];
        w_win_a = '0;
        w_win_b = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win == PW'(j)) begin
                w_win_a = i_op_a[32*j +: 32];
                w_win_b = i_op_b[32*j +: 32];
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_idx_n   = r_idx;
        w_cnt_n   = r_run_cnt;
        w_gnt_n   = '0;
        w_valid_n = '0;
        w_sum_n   = r_rsp_sum;
        w_err_n   = r_rsp_err;
        w_n1_n    = r_n1;
        w_n2_n    = r_n2;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n = LOAD;
                    w_gnt_n   = ONE << w_win;
                    w_n1_n    = w_win_a;
                    w_n2_n    = w_win_b;
                    w_idx_n   = w_win;
                    w_ptr_n   = (w_win == LAST_IDX) ? '0 : w_win + 1'b1;
                end
            end
            LOAD: begin
                w_state_n = RUN;
                w_cnt_n   = '0;
            end
            RUN: begin
                if (r_run_cnt != 8'hFF) begin
                    w_cnt_n = r_run_cnt + 8'd1;
                end
                // The adder's done is sticky from the previous job until our start reaches it.
                if (i_add_done && r_run_cnt >= 8'd2) begin
                    w_state_n = RESP;
                    w_sum_n   = i_add_sum;
                    w_err_n   = 1'b0;
                    w_valid_n = ONE << r_idx;
                end
`ifdef FP_SCHED_TIMEOUT_EN
                else if (r_run_cnt >= 8'(TIMEOUT - 1)) begin
                    w_state_n = RESP;
                    w_sum_n   = '0;
                    w_err_n   = 1'b1;
                    w_valid_n = ONE << r_idx;
                end
`endif
            end
            RESP: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
`ifdef FP_SCHED_TIMEOUT_EN
`else
        w_err_n = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or posedge i_restart) begin
        if (i_restart) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_idx       <= '0;
            r_run_cnt   <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_n1        <= '0;
            r_n2        <= '0;
            r_start     <= 1'b0;
            r_restart   <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_idx       <= w_idx_n;
            r_run_cnt   <= w_cnt_n;
            r_gnt       <= w_gnt_n;
            r_rsp_valid <= w_valid_n;
            r_rsp_sum   <= w_sum_n;
            r_rsp_err   <= w_err_n;
            r_busy      <= (w_state_n != IDLE);
            r_n1        <= w_n1_n;
            r_n2        <= w_n2_n;
            r_start     <= (w_state_n == RUN);
            r_restart   <= (w_state_n != RUN);
        end
    end

    assign o_gnt         = r_gnt;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_sum     = r_rsp_sum;
    assign o_rsp_err     = r_rsp_err;
    assign o_busy        = r_busy;
    assign o_add_n1      = r_n1;
    assign o_add_n2      = r_n2;
    assign o_add_start   = r_start;
    assign o_add_restart = r_restart;

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched with a behavioural adder stub whose done is sticky.
// Expected grants/responses are queued at stimulus time and popped by a negedge monitor.
module tb_fp_add_sched;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int LAT     = 10;

    typedef struct packed {
        logic [NREQ-1:0] valid;
        logic [31:0]     sum;
        logic            err;
    } rsp_t;

    logic              clk     = 1'b0;
    logic              restart = 1'b0;
    logic [NREQ-1:0]   req     = '0;
    logic [31:0]       opA [NREQ];
    logic [31:0]       opB [NREQ];
    logic [32*NREQ-1:0] opAPacked, opBPacked;

    logic [NREQ-1:0] gnt, rspValid;
    logic [31:0]     rspSum, addN1, addN2;
    logic            rspErr, busy, addStart, addRestart;

    logic        stubDone   = 1'b0;
    logic        stubActive = 1'b0;
    logic        stubArmed  = 1'b1;
    logic        stubStartQ = 1'b0;
    logic        stubHang   = 1'b0;
    logic [31:0] stubSum    = '0;
    int          stubCnt    = 0;

    logic [NREQ-1:0] gntQ [$];
    rsp_t            rspQ [$];
    rsp_t            expRsp;
    int              nChecks = 0;
    int              nPass   = 0;
    int              cycles;

    fp_add_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_restart(restart), .i_req(req),
        .i_op_a(opAPacked), .i_op_b(opBPacked),
        .o_gnt(gnt), .o_rsp_valid(rspValid), .o_rsp_sum(rspSum), .o_rsp_err(rspErr),
        .o_busy(busy), .o_add_n1(addN1), .o_add_n2(addN2),
        .o_add_start(addStart), .o_add_restart(addRestart),
        .i_add_sum(stubSum), .i_add_done(stubDone)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            opAPacked[32*i +: 32] = opA[i];
            opBPacked[32*i +: 32] = opB[i];
        end
    end

    function automatic logic [31:0] lookupSum(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40A00000, 32'h3F800000}: return 32'h40C00000;
            {32'h41200000, 32'h40A00000}: return 32'h41700000;
            {32'h3F000000, 32'h3F000000}: return 32'h3F800000;
            {32'h40400000, 32'h40800000}: return 32'h40E00000;
            {32'h41000000, 32'h41000000}: return 32'h41800000;
            {32'h40400000, 32'h3F800000}: return 32'h40800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Adder stub: start passes through an input register, so a stale done lingers two RUN cycles.
    always @(posedge clk) begin
        stubStartQ <= addStart & ~addRestart;
        if (addRestart) begin
            stubActive <= 1'b0;
            stubArmed  <= 1'b1;
        end else if (stubStartQ && stubArmed) begin
            stubArmed  <= 1'b0;
            stubActive <= 1'b1;
            stubDone   <= 1'b0;
            stubCnt    <= LAT;
        end else if (stubActive) begin
            stubCnt <= stubCnt - 1;
            if (stubCnt == 1) begin
                stubActive <= 1'b0;
                if (!stubHang) begin
                    stubDone <= 1'b1;
                    stubSum  <= lookupSum(addN1, addN2);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    // Monitor: clients drop req once granted; grants and responses are popped from the scoreboard.
    always @(negedge clk) begin
        if (gnt != '0) begin
            req = req & ~gnt;
            if (gntQ.size() == 0) checkOutput("gntUnexpected", 32'(gnt), 32'h0);
            else                  checkOutput("gntOrder", 32'(gnt), 32'(gntQ.pop_front()));
        end
        if (rspValid != '0) begin
            if (rspQ.size() == 0) begin
                checkOutput("rspUnexpected", 32'(rspValid), 32'h0);
            end else begin
                expRsp = rspQ.pop_front();
                checkOutput("rspValid", 32'(rspValid), 32'(expRsp.valid));
                checkOutput("rspSum", rspSum, expRsp.sum);
                checkOutput("rspErr", 32'(rspErr), 32'(expRsp.err));
            end
        end
    end

    task automatic setOperands(input int c, input logic [31:0] a, input logic [31:0] b);
        opA[c] = a;
        opB[c] = b;
    endtask

    task automatic expectTxn(input logic [NREQ-1:0] who, input logic [31:0] sum, input logic err);
        rsp_t r;
        r = '{valid: who, sum: sum, err: err};
        gntQ.push_back(who);
        rspQ.push_back(r);
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] bits);
        @(posedge clk);
        #1;
        req = req | bits;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrained(input int budget);
        int n = 0;
        while ((gntQ.size() != 0 || rspQ.size() != 0 || busy || req != '0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainBound", 32'(n < budget), 32'h1);
    endtask

    task automatic waitStart(input int budget);
        int n = 0;
        while (!addStart && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("startSeen", 32'(addStart), 32'h1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".gnt"}, 32'(gnt), 32'h0);
        checkOutput({tag, ".rspValid"}, 32'(rspValid), 32'h0);
        checkOutput({tag, ".rspSum"}, rspSum, 32'h0);
        checkOutput({tag, ".rspErr"}, 32'(rspErr), 32'h0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'h0);
        checkOutput({tag, ".addN1"}, addN1, 32'h0);
        checkOutput({tag, ".addN2"}, addN2, 32'h0);
        checkOutput({tag, ".addStart"}, 32'(addStart), 32'h0);
        checkOutput({tag, ".addRestart"}, 32'(addRestart), 32'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = '0;
            opB[i] = '0;
        end
        #1 restart = 1'b1;
        #20;
        checkResetState("reset");
        restart = 1'b0;

        // Single client 0: 1.0 + 2.0, with latency and handshake checks.
        setOperands(0, 32'h3F800000, 32'h40000000);
        expectTxn(4'b0001, 32'h40400000, 1'b0);
        applyStimulus(4'b0001);
        @(posedge clk);
        #1;
        checkOutput("gntLatency", 32'(gnt), 32'h1);
        checkOutput("addN1Load", addN1, 32'h3F800000);
        checkOutput("addN2Load", addN2, 32'h40000000);
        checkOutput("restartLoad", 32'(addRestart), 32'h1);
        checkOutput("startLoad", 32'(addStart), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("gntPulse", 32'(gnt), 32'h0);
        checkOutput("startRun", 32'(addStart), 32'h1);
        checkOutput("restartRun", 32'(addRestart), 32'h0);
        waitDrained(200);
        checkOutput("sumHeld", rspSum, 32'h40400000);
        checkOutput("restartIdle", 32'(addRestart), 32'h1);

        // req=1010 with pointer at 1: client 1 then client 3.
        setOperands(1, 32'h40A00000, 32'h3F800000);
        setOperands(3, 32'h41200000, 32'h40A00000);
        expectTxn(4'b0010, 32'h40C00000, 1'b0);
        expectTxn(4'b1000, 32'h41700000, 1'b0);
        applyStimulus(4'b1010);
        waitDrained(400);

        // req=1111 with pointer wrapped to 0.
        setOperands(0, 32'h3F000000, 32'h3F000000);
        setOperands(1, 32'h40400000, 32'h40800000);
        setOperands(2, 32'h41000000, 32'h41000000);
        setOperands(3, 32'h3F800000, 32'h40000000);
        expectTxn(4'b0001, 32'h3F800000, 1'b0);
        expectTxn(4'b0010, 32'h40E00000, 1'b0);
        expectTxn(4'b0100, 32'h41800000, 1'b0);
        expectTxn(4'b1000, 32'h40400000, 1'b0);
        applyStimulus(4'b1111);
        waitDrained(800);

        // Back-to-back with stale done (previous sum 3.0 still presented): expect 4.0.
        setOperands(2, 32'h40400000, 32'h3F800000);
        expectTxn(4'b0100, 32'h40800000, 1'b0);
        applyStimulus(4'b0100);
        waitDrained(200);

        // Restart in the fifth RUN cycle aborts with no response.
        setOperands(1, 32'h41000000, 32'h41000000);
        gntQ.push_back(4'b0010);
        applyStimulus(4'b0010);
        waitStart(10);
        waitCycles(4);
        restart = 1'b1;
        #1;
        checkResetState("abort");
        waitCycles(1);
        restart = 1'b0;
        waitCycles(30);
        checkOutput("abortIdleBusy", 32'(busy), 32'h0);

        // Pointer back at 0: req=0101 serves client 0 before client 2.
        setOperands(0, 32'h40A00000, 32'h3F800000);
        setOperands(2, 32'h3F800000, 32'h40000000);
        expectTxn(4'b0001, 32'h40C00000, 1'b0);
        expectTxn(4'b0100, 32'h40400000, 1'b0);
        applyStimulus(4'b0101);
        waitDrained(400);

        // Client 3 requests and withdraws during client 0's RUN; it must never be granted.
        setOperands(0, 32'h41200000, 32'h40A00000);
        setOperands(3, 32'h41000000, 32'h41000000);
        expectTxn(4'b0001, 32'h41700000, 1'b0);
        applyStimulus(4'b0001);
        waitStart(10);
        waitCycles(2);
        req[3] = 1'b1;
        waitCycles(4);
        req[3] = 1'b0;
        waitDrained(200);

        // Pointer still at 1: req=0101 serves client 2 before client 0.
        setOperands(0, 32'h40A00000, 32'h3F800000);
        setOperands(2, 32'h3F000000, 32'h3F000000);
        expectTxn(4'b0100, 32'h3F800000, 1'b0);
        expectTxn(4'b0001, 32'h40C00000, 1'b0);
        applyStimulus(4'b0101);
        waitDrained(400);

        // Adder that never finishes.
        stubHang = 1'b1;
        setOperands(3, 32'h40400000, 32'h40800000);
`ifdef FP_SCHED_TIMEOUT_EN
        expectTxn(4'b1000, 32'h0, 1'b1);
        applyStimulus(4'b1000);
        waitStart(10);
        cycles = 0;
        while (rspValid == '0 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("timeoutCycles", 32'(cycles), 32'(TIMEOUT));
        waitDrained(100);
        stubHang = 1'b0;
        expectTxn(4'b1000, 32'h40E00000, 1'b0);
        applyStimulus(4'b1000);
        waitDrained(200);
        checkOutput("errCleared", 32'(rspErr), 32'h0);
`else
        gntQ.push_back(4'b1000);
        applyStimulus(4'b1000);
        waitStart(10);
        waitCycles(100);
        checkOutput("hangBusy", 32'(busy), 32'h1);
        checkOutput("hangStart", 32'(addStart), 32'h1);
        checkOutput("hangErrTied", 32'(rspErr), 32'h0);
        restart = 1'b1;
        #1;
        checkResetState("hangAbort");
        waitCycles(1);
        restart = 1'b0;
        stubHang = 1'b0;
        expectTxn(4'b1000, 32'h40E00000, 1'b0);
        applyStimulus(4'b1000);
        waitDrained(200);
`endif

        waitCycles(5);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
